// File: rtl/alu_pkg.sv
// Shared constants for the MIPS ALU control / multiply-divide block:
// ALUcontrole codes, R-type funct codes, FSM state encoding and the
// operation descriptor handed to the iterative datapath.
package alu_pkg;

  localparam int unsigned FN_W   = 6;
  localparam int unsigned ALU_CW = 4;

  // ALUcontrole codes
  localparam logic [ALU_CW-1:0] ALU_AND  = 4'd0;
  localparam logic [ALU_CW-1:0] ALU_OR   = 4'd1;
  localparam logic [ALU_CW-1:0] ALU_ADD  = 4'd2;
  localparam logic [ALU_CW-1:0] ALU_SUB  = 4'd6;
  localparam logic [ALU_CW-1:0] ALU_SLT  = 4'd7;
  localparam logic [ALU_CW-1:0] ALU_SLTU = 4'd8;
  localparam logic [ALU_CW-1:0] ALU_NOR  = 4'd12;
  localparam logic [ALU_CW-1:0] ALU_XOR  = 4'd13;

  // R-type funct codes
  localparam logic [FN_W-1:0] FN_MFHI  = 6'd16;
  localparam logic [FN_W-1:0] FN_MTHI  = 6'd17;
  localparam logic [FN_W-1:0] FN_MFLO  = 6'd18;
  localparam logic [FN_W-1:0] FN_MTLO  = 6'd19;
  localparam logic [FN_W-1:0] FN_MULT  = 6'd24;
  localparam logic [FN_W-1:0] FN_MULTU = 6'd25;
  localparam logic [FN_W-1:0] FN_DIV   = 6'd26;
  localparam logic [FN_W-1:0] FN_DIVU  = 6'd27;
  localparam logic [FN_W-1:0] FN_ADD   = 6'd32;
  localparam logic [FN_W-1:0] FN_ADDU  = 6'd33;
  localparam logic [FN_W-1:0] FN_SUB   = 6'd34;
  localparam logic [FN_W-1:0] FN_SUBU  = 6'd35;
  localparam logic [FN_W-1:0] FN_AND   = 6'd36;
  localparam logic [FN_W-1:0] FN_OR    = 6'd37;
  localparam logic [FN_W-1:0] FN_XOR   = 6'd38;
  localparam logic [FN_W-1:0] FN_NOR   = 6'd39;
  localparam logic [FN_W-1:0] FN_SLT   = 6'd42;
  localparam logic [FN_W-1:0] FN_SLTU  = 6'd43;

  // FSM state encoding
  localparam logic [0:0] OCIOSO = 1'b0;
  localparam logic [0:0] CALC   = 1'b1;

  // Operation descriptor latched by the datapath at start
  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_op_t;

  // Any funct that touches HI/LO or the multiply/divide unit
  function automatic logic is_md_funct(input logic [FN_W-1:0] fn);
    return (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                       FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

  // Functs that start the multiply/divide unit
  function automatic logic is_muldiv_funct(input logic [FN_W-1:0] fn);
    return (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

endpackage

// File: rtl/alu_muldiv_control_muldiv_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring
// divide, one bit per step, on operand magnitudes with sign fix-up on the
// final step. Results are presented combinationally on the last step so
// the owner can capture them on that same edge.
// Optional: MULDIV_FAST_MULT_EN replaces the multiply result with a single
// combinational product of the latched magnitudes.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic [WIDTH-1:0] acc;      // partial product high half / partial remainder
  logic [WIDTH-1:0] qr;       // multiplier / dividend-quotient shift register
  logic [WIDTH-1:0] dr;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_raw;    // original dividend for divide-by-zero
  logic             is_div;
  logic             neg_q;    // product or quotient sign
  logic             neg_r;    // remainder sign
  logic             div_zero;

  logic             sa, sb;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH-1:0] acc_n, qr_n;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic [WIDTH+1:0] ddiff;
  logic             dfit;
  logic [W2-1:0]    prod_mag, prod_s;
  logic [WIDTH-1:0] quot_s, rem_s;

  // Operand magnitudes for the start cycle
  always_comb begin
    sa = op.is_signed & a[WIDTH-1];
    sb = op.is_signed & b[WIDTH-1];
    ma = sa ? (~a + WIDTH'(1)) : a;
    mb = sb ? (~b + WIDTH'(1)) : b;
  end

  // One iteration of either algorithm
  always_comb begin
    msum   = {1'b0, acc} + (qr[0] ? {1'b0, dr} : (WIDTH + 1)'(0));
    dshift = {acc, qr[WIDTH-1]};
    ddiff  = {1'b0, dshift} - {2'b00, dr};
    dfit   = ~ddiff[WIDTH+1];
    if (is_div) begin
      acc_n = dfit ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
      qr_n  = {qr[WIDTH-2:0], dfit};
    end else begin
      acc_n = msum[WIDTH:1];
      qr_n  = {msum[0], qr[WIDTH-1:1]};
    end
  end

  // Sign fix-up and special cases on the post-step values
  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prod_mag = W2'(qr) * W2'(dr);
`else
    prod_mag = {acc_n, qr_n};
`endif
    prod_s = neg_q ? (~prod_mag + W2'(1)) : prod_mag;
    quot_s = neg_q ? (~qr_n + WIDTH'(1)) : qr_n;
    rem_s  = neg_r ? (~acc_n + WIDTH'(1)) : acc_n;
    if (div_zero) begin
      quot_s = '1;
      rem_s  = a_raw;
    end
    if (is_div) begin
      hi_c = rem_s;
      lo_c = quot_s;
    end else begin
      hi_c = prod_s[W2-1:WIDTH];
      lo_c = prod_s[WIDTH-1:0];
    end
    done_c = step & last;
  end

  // Operand latch on start, one iteration per step
  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      qr       <= '0;
      dr       <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      acc      <= '0;
      qr       <= ma;
      dr       <= mb;
      a_raw    <= a;
      is_div   <= op.is_div;
      neg_q    <= sa ^ sb;
      neg_r    <= sa;
      div_zero <= op.is_div & (b == '0);
    end else if (step) begin
      acc <= acc_n;
      qr  <= qr_n;
    end
  end

endmodule

// File: rtl/alu_muldiv_control.sv
// MIPS ALU control with HI/LO multiply/divide unit: decodes ALUOp/funct
// into ALUcontrole, sequences the iterative mult/div, owns HI/LO and
// stalls HI/LO-related instructions while the unit is busy.
// Optional: MULDIV_FAST_MULT_EN gives mult/multu a one-cycle busy window.
module alu_muldiv_control
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              habilita,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        codigoFuncao,
  input  logic [WIDTH-1:0]  operandoA,
  input  logic [WIDTH-1:0]  operandoB,
  output logic [CTRL_W-1:0] ALUcontrole,
  output logic [WIDTH-1:0]  resultadoMD,
  output logic              usaMD,
  output logic              ocupado,
  output logic              stall
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hi, lo;
  logic [ALU_CW-1:0] alu_code;

  logic             r_type;
  logic             is_md, is_muldiv, is_mult;
  logic             is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic             issue, accept;
  logic             md_start, md_step, md_last, md_done;
  logic [CNT_W-1:0] cnt_load;
  md_op_t           md_op;
  logic [WIDTH-1:0] md_hi, md_lo;

  // ALUcontrole decode
  always_comb begin
    alu_code = ALU_ADD;
    case (ALUOp)
      2'd1: alu_code = ALU_SUB;
      2'd2: begin
        case (codigoFuncao)
          FN_ADD, FN_ADDU: alu_code = ALU_ADD;
          FN_SUB, FN_SUBU: alu_code = ALU_SUB;
          FN_AND:          alu_code = ALU_AND;
          FN_OR:           alu_code = ALU_OR;
          FN_XOR:          alu_code = ALU_XOR;
          FN_NOR:          alu_code = ALU_NOR;
          FN_SLT:          alu_code = ALU_SLT;
          FN_SLTU:         alu_code = ALU_SLTU;
          default:         alu_code = ALU_ADD;
        endcase
      end
      default: alu_code = ALU_ADD;
    endcase
  end

  assign ALUcontrole = CTRL_W'(alu_code);

  // HI/LO instruction classification and stall
  always_comb begin
    r_type    = (ALUOp == 2'd2);
    is_md     = r_type & is_md_funct(codigoFuncao);
    is_muldiv = r_type & is_muldiv_funct(codigoFuncao);
    is_mult   = r_type & ((codigoFuncao == FN_MULT) | (codigoFuncao == FN_MULTU));
    is_mfhi   = r_type & (codigoFuncao == FN_MFHI);
    is_mflo   = r_type & (codigoFuncao == FN_MFLO);
    is_mthi   = r_type & (codigoFuncao == FN_MTHI);
    is_mtlo   = r_type & (codigoFuncao == FN_MTLO);
    stall     = habilita & ocupado & is_md;
    issue     = habilita & ~stall;
    accept    = issue & is_muldiv & (state == OCIOSO);
    usaMD     = habilita & (is_mfhi | is_mflo);
    if (is_mfhi) begin
      resultadoMD = hi;
    end else if (is_mflo) begin
      resultadoMD = lo;
    end else begin
      resultadoMD = '0;
    end
    md_op.is_div    = (codigoFuncao == FN_DIV) | (codigoFuncao == FN_DIVU);
    md_op.is_signed = (codigoFuncao == FN_MULT) | (codigoFuncao == FN_DIV);
  end

  // Busy window length: full width, or one cycle for a fast multiply
  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    cnt_load = is_mult ? CNT_W'(1) : CNT_W'(WIDTH);
`else
    cnt_load = CNT_W'(WIDTH);
`endif
  end

  // FSM next state, counter and datapath handshake
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    md_start = 1'b0;
    md_step  = 1'b0;
    md_last  = (cnt == CNT_W'(1));
    case (state)
      OCIOSO: begin
        if (accept) begin
          state_n  = CALC;
          cnt_n    = cnt_load;
          md_start = 1'b1;
        end
      end
      CALC: begin
        md_step = 1'b1;
        if (md_last) begin
          state_n = OCIOSO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = OCIOSO;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM state, counter and busy flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= OCIOSO;
      cnt     <= '0;
      ocupado <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ocupado <= (state_n == CALC);
    end
  end

  // HI/LO: unit results on completion, mthi/mtlo otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (md_done) begin
      hi <= md_hi;
      lo <= md_lo;
    end else begin
      if (issue & is_mthi) hi <= operandoA;
      if (issue & is_mtlo) lo <= operandoA;
    end
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv_iter (
    .clock  (clock),
    .reset  (reset),
    .start  (md_start),
    .step   (md_step),
    .last   (md_last),
    .op     (md_op),
    .a      (operandoA),
    .b      (operandoB),
    .done_c (md_done),
    .hi_c   (md_hi),
    .lo_c   (md_lo)
  );

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Self-checking bench for alu_muldiv_control: decode sweep, randomized
// mult/div against an arithmetic reference, directed corner cases, stall
// behaviour and mid-operation reset.
module tb_alu_muldiv_control;
  import alu_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MULT_BUSY = 1;
`else
  localparam int MULT_BUSY = 32;
`endif
  localparam int DIV_BUSY = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        habilita;
  logic [1:0]  ALUOp;
  logic [5:0]  codigoFuncao;
  logic [31:0] operandoA, operandoB;
  logic [3:0]  ALUcontrole;
  logic [31:0] resultadoMD;
  logic        usaMD, ocupado, stall;

  int n_pass  = 0;
  int n_total = 0;

  alu_muldiv_control #(.WIDTH(32), .CTRL_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .habilita     (habilita),
    .ALUOp        (ALUOp),
    .codigoFuncao (codigoFuncao),
    .operandoA    (operandoA),
    .operandoB    (operandoB),
    .ALUcontrole  (ALUcontrole),
    .resultadoMD  (resultadoMD),
    .usaMD        (usaMD),
    .ocupado      (ocupado),
    .stall        (stall)
  );

  always #5 clock = ~clock;

  // Reference: {HI, LO} from plain arithmetic
  function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sq, sr;
    ref_md = '0;
    case (fn)
      FN_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        ref_md = 64'(sp);
      end
      FN_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        ref_md = up;
      end
      FN_DIV: begin
        if (b == 32'd0) ref_md = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_md = {32'd0, 32'h8000_0000};
        else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          ref_md = {32'(sr), 32'(sq)};
        end
      end
      FN_DIVU: begin
        if (b == 32'd0) ref_md = {a, 32'hFFFF_FFFF};
        else ref_md = {a % b, a / b};
      end
      default: ref_md = '0;
    endcase
  endfunction

  function automatic int ref_busy(input logic [5:0] fn);
    return (fn == FN_MULT || fn == FN_MULTU) ? MULT_BUSY : DIV_BUSY;
  endfunction

  // Issue one mult/div and count the cycles ocupado stays high
  task automatic issue_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int busy);
    @(negedge clock);
    habilita = 1'b1; ALUOp = 2'd2; codigoFuncao = fn; operandoA = a; operandoB = b;
    @(negedge clock);
    habilita = 1'b0; codigoFuncao = FN_ADD;
    busy = 0;
    while (ocupado === 1'b1 && busy < 200) begin
      busy++;
      @(negedge clock);
    end
  endtask

  // Read HI and LO through mfhi/mflo
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clock);
    habilita = 1'b1; ALUOp = 2'd2; codigoFuncao = FN_MFHI;
    #1 hi = resultadoMD;
    codigoFuncao = FN_MFLO;
    #1 lo = resultadoMD;
    habilita = 1'b0; codigoFuncao = FN_ADD;
  endtask

  task automatic test_reset();
    reset = 1'b1; habilita = 1'b0; ALUOp = 2'd0; codigoFuncao = 6'd0;
    operandoA = '0; operandoB = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_total++;
    if (ocupado !== 1'b0) $display("FAIL reset_ocupado got=%b exp=0", ocupado); else n_pass++;
    n_total++;
    if (usaMD !== 1'b0) $display("FAIL reset_usaMD got=%b exp=0", usaMD); else n_pass++;
    habilita = 1'b1; ALUOp = 2'd2; codigoFuncao = FN_MFHI;
    #1;
    n_total++;
    if (resultadoMD !== 32'd0 || usaMD !== 1'b1 || stall !== 1'b0)
      $display("FAIL reset_hi got=%h usa=%b stall=%b exp=0 1 0", resultadoMD, usaMD, stall);
    else n_pass++;
    codigoFuncao = FN_MFLO;
    #1;
    n_total++;
    if (resultadoMD !== 32'd0) $display("FAIL reset_lo got=%h exp=0", resultadoMD); else n_pass++;
    habilita = 1'b0;
  endtask

  task automatic test_decode();
    logic [5:0] fns [9];
    logic [3:0] exps [9];
    logic [3:0] e;
    fns  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd50};
    exps = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd13, 4'd12, 4'd7, 4'd8, 4'd2};
    @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      ALUOp = 2'd2; codigoFuncao = fns[i];
      #1;
      n_total++;
      if (ALUcontrole !== exps[i])
        $display("FAIL decode_r funct=%0d got=%0d exp=%0d", fns[i], ALUcontrole, exps[i]);
      else n_pass++;
    end
    for (int i = 0; i < 12; i++) begin
      ALUOp = 2'(i % 3 == 0 ? 0 : (i % 3 == 1 ? 1 : 3));
      codigoFuncao = 6'($urandom_range(0, 63));
      e = (ALUOp == 2'd1) ? 4'd6 : 4'd2;
      #1;
      n_total++;
      if (ALUcontrole !== e)
        $display("FAIL decode_op aluop=%0d funct=%0d got=%0d exp=%0d", ALUOp, codigoFuncao, ALUcontrole, e);
      else n_pass++;
    end
  endtask

  task automatic run_check(input string tag, input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b);
    int          busy;
    logic [31:0] hi, lo;
    logic [63:0] e;
    e = ref_md(fn, a, b);
    issue_md(fn, a, b, busy);
    n_total++;
    if (busy !== ref_busy(fn))
      $display("FAIL %s_busy fn=%0d got=%0d exp=%0d", tag, fn, busy, ref_busy(fn));
    else n_pass++;
    read_hilo(hi, lo);
    n_total++;
    if ({hi, lo} !== e)
      $display("FAIL %s_hilo fn=%0d a=%h b=%h got=%h_%h exp=%h_%h", tag, fn, a, b, hi, lo,
               e[63:32], e[31:0]);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_check("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("mult_neg",  FN_MULT,  32'hFFFF_FFF9, 32'd3);
    run_check("div_neg",   FN_DIV,   32'hFFFF_FFF9, 32'd2);
    run_check("div_zero",  FN_DIV,   32'd5,         32'd0);
    run_check("div_min",   FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_check("divu_zero", FN_DIVU,  32'hDEAD_BEEF, 32'd0);
    run_check("mult_6x7",  FN_MULT,  32'd6,         32'd7);
  endtask

  task automatic test_random_md();
    logic [5:0]  fn;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      fn = 6'(24 + $urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'(int'($urandom_range(0, 20)) - 10);
        1: begin a = 32'(int'($urandom_range(0, 2000)) - 1000); b = 32'(int'($urandom_range(1, 40)) - 20); end
        default: ;
      endcase
      run_check("rand", fn, a, b);
    end
  endtask

  task automatic test_stall();
    int          cyc, stall_cyc, exp_rem;
    logic [63:0] e;
    e = ref_md(FN_MULT, 32'hFFFF_FFF9, 32'd3);
    @(negedge clock);
    habilita = 1'b1; ALUOp = 2'd2; codigoFuncao = FN_MULT;
    operandoA = 32'hFFFF_FFF9; operandoB = 32'd3;
    @(negedge clock);
    habilita = 1'b0; codigoFuncao = FN_ADD;
    @(negedge clock);
    @(negedge clock);
    habilita = 1'b1; codigoFuncao = FN_ADD;
    #1;
    n_total++;
    if (stall !== 1'b0 || ALUcontrole !== 4'd2)
      $display("FAIL add_during_busy stall=%b alu=%0d exp=0 2", stall, ALUcontrole);
    else n_pass++;
    n_total++;
    if (ocupado !== (MULT_BUSY >= 3))
      $display("FAIL busy_at_cycle3 got=%b exp=%b", ocupado, (MULT_BUSY >= 3));
    else n_pass++;
    @(negedge clock);
    codigoFuncao = FN_MFLO;
    #1;
    cyc = 0; stall_cyc = 0;
    while (ocupado === 1'b1 && cyc < 200) begin
      if (stall === 1'b1) stall_cyc++;
      cyc++;
      @(negedge clock);
      #1;
    end
    exp_rem = (MULT_BUSY > 3) ? MULT_BUSY - 3 : 0;
    n_total++;
    if (cyc !== exp_rem || stall_cyc !== exp_rem)
      $display("FAIL mflo_stall_cycles got=%0d/%0d exp=%0d", stall_cyc, cyc, exp_rem);
    else n_pass++;
    n_total++;
    if (stall !== 1'b0 || usaMD !== 1'b1 || resultadoMD !== e[31:0])
      $display("FAIL mflo_after_busy stall=%b usa=%b got=%h exp=0 1 %h", stall, usaMD,
               resultadoMD, e[31:0]);
    else n_pass++;
    habilita = 1'b0; codigoFuncao = FN_ADD;
  endtask

  task automatic test_reset_midop();
    logic [31:0] hi, lo;
    run_check("pre_reset", FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clock);
    habilita = 1'b1; ALUOp = 2'd2; codigoFuncao = FN_DIVU;
    operandoA = 32'hFFFF_0000; operandoB = 32'd3;
    @(negedge clock);
    habilita = 1'b0; codigoFuncao = FN_ADD;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_total++;
    if (ocupado !== 1'b0) $display("FAIL midop_reset_ocupado got=%b exp=0", ocupado); else n_pass++;
    read_hilo(hi, lo);
    n_total++;
    if (hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL midop_reset_hilo got=%h_%h exp=0_0", hi, lo);
    else n_pass++;
    @(negedge clock);
    habilita = 1'b1; ALUOp = 2'd2; codigoFuncao = FN_MTHI; operandoA = 32'h1234;
    @(negedge clock);
    codigoFuncao = FN_MFHI;
    #1;
    n_total++;
    if (resultadoMD !== 32'h1234) $display("FAIL mthi_mfhi got=%h exp=1234", resultadoMD); else n_pass++;
    @(negedge clock);
    codigoFuncao = FN_MTLO; operandoA = 32'hCAFE_F00D;
    @(negedge clock);
    codigoFuncao = FN_MFLO;
    #1;
    n_total++;
    if (resultadoMD !== 32'hCAFE_F00D) $display("FAIL mtlo_mflo got=%h exp=cafef00d", resultadoMD); else n_pass++;
    habilita = 1'b0; codigoFuncao = FN_ADD;
  endtask

  task automatic test_blocked_mthi();
    logic [31:0] hi, lo;
    logic [63:0] e;
    int          busy;
    e = ref_md(FN_DIVU, 32'd100, 32'd7);
    @(negedge clock);
    habilita = 1'b1; ALUOp = 2'd2; codigoFuncao = FN_DIVU; operandoA = 32'd100; operandoB = 32'd7;
    @(negedge clock);
    codigoFuncao = FN_MTHI; operandoA = 32'h5555_5555;
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL mthi_blocked_stall got=%b exp=1", stall); else n_pass++;
    habilita = 1'b0; codigoFuncao = FN_ADD;
    busy = 1;
    while (ocupado === 1'b1 && busy < 200) begin
      busy++;
      @(negedge clock);
    end
    read_hilo(hi, lo);
    n_total++;
    if ({hi, lo} !== e) $display("FAIL mthi_blocked_hilo got=%h_%h exp=%h_%h", hi, lo, e[63:32], e[31:0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_directed();
    test_random_md();
    test_stall();
    test_blocked_mthi();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
